// File: rtl/cordic_range_if.sv
// Request/result and core-side signals of the cordic angle-reduction stage.
// The slave modport is the cordic_range block; master is its driver/core stub.
interface cordic_range_if;
    logic        start;
    logic [15:0] angle;
    logic        busy;
    logic [15:0] theta;
    logic        c_bgn;
    logic        c_fin;
    logic [15:0] c_cos;
    logic [15:0] cos_out;
    logic        neg;
    logic        done;

    modport master (
        output start, angle, c_fin, c_cos,
        input  busy, theta, c_bgn, cos_out, neg, done
    );

    modport slave (
        input  start, angle, c_fin, c_cos,
        output busy, theta, c_bgn, cos_out, neg, done
    );
endinterface

// File: rtl/cordic_range.sv
// Folds a Q3.12 angle into [-pi/2, pi/2], sequences the cordic cosine core and sign-corrects its result.
// Optional build macro CORDIC_RANGE_SAT_EN clamps the captured cosine to +/-1.0.
//
// state  | meaning
// IDLE   | waiting for start; angle captured on start
// REDUCE | subtract/add 2*pi until angle lies in [-pi, pi]
// FOLD   | mirror about +/-pi/2, set neg, convert to Q2.14 theta
// ISSUE  | one-cycle c_bgn pulse to the core
// WAIT   | theta held; capture corrected c_cos on c_fin
// DONE   | one-cycle done pulse
module cordic_range #(
    parameter logic [15:0] TWO_PI  = 16'h6488,
    parameter logic [15:0] PI      = 16'h3244,
    parameter logic [15:0] HALF_PI = 16'h1922
) (
    input  logic           clk,
    input  logic           rst_b,
    cordic_range_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        FOLD   = 3'd2,
        ISSUE  = 3'd3,
        WAIT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic signed [15:0] TWO_PI_S   = signed'(TWO_PI);
    localparam logic signed [15:0] PI_S       = signed'(PI);
    localparam logic signed [15:0] HALF_PI_S  = signed'(HALF_PI);
    localparam logic signed [15:0] NEG_PI_S   = 16'sd0 - signed'(PI);
    localparam logic signed [15:0] NEG_HALF_S = 16'sd0 - signed'(HALF_PI);

    state_t             state, state_n;
    logic signed [15:0] a_reg, a_n;
    logic        [15:0] theta_reg, theta_n;
    logic        [15:0] cos_reg, cos_n;
    logic               neg_reg, neg_n;
    logic               bgn_reg, done_reg, busy_reg;
    logic signed [15:0] f;
    logic signed [15:0] corr;
    logic signed [15:0] cap_val;

    // Sign correction wraps in 16 bits; the optional clamp acts on the wrapped value.
    always_comb begin
        corr = neg_reg ? (16'sd0 - signed'(bus.c_cos)) : signed'(bus.c_cos);
`ifdef CORDIC_RANGE_SAT_EN
        if (corr > 16'sh4000) begin
            cap_val = 16'sh4000;
        end else if (corr < 16'shC000) begin
            cap_val = 16'shC000;
        end else begin
            cap_val = corr;
        end
`else
        cap_val = corr;
`endif
    end

    always_comb begin
        state_n = state;
        a_n     = a_reg;
        theta_n = theta_reg;
        cos_n   = cos_reg;
        neg_n   = neg_reg;
        f       = a_reg;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_n     = signed'(bus.angle);
                    state_n = REDUCE;
                end
            end
            REDUCE: begin
                if (a_reg > PI_S) begin
                    a_n = a_reg - TWO_PI_S;
                end else if (a_reg < NEG_PI_S) begin
                    a_n = a_reg + TWO_PI_S;
                end else begin
                    state_n = FOLD;
                end
            end
            FOLD: begin
                // Exactly +/-pi/2 stays unfolded; +/-pi folds to zero with negation.
                if (a_reg > HALF_PI_S) begin
                    f     = PI_S - a_reg;
                    neg_n = 1'b1;
                end else if (a_reg < NEG_HALF_S) begin
                    f     = NEG_PI_S - a_reg;
                    neg_n = 1'b1;
                end else begin
                    f     = a_reg;
                    neg_n = 1'b0;
                end
                theta_n = {f[13:0], 2'b00};
                state_n = ISSUE;
            end
            ISSUE: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (bus.c_fin) begin
                    cos_n   = cap_val;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Status outputs are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state     <= IDLE;
            a_reg     <= '0;
            theta_reg <= '0;
            cos_reg   <= '0;
            neg_reg   <= 1'b0;
            bgn_reg   <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state     <= state_n;
            a_reg     <= a_n;
            theta_reg <= theta_n;
            cos_reg   <= cos_n;
            neg_reg   <= neg_n;
            bgn_reg   <= (state_n == ISSUE);
            done_reg  <= (state_n == DONE);
            busy_reg  <= (state_n != IDLE);
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.theta   = theta_reg;
    assign bus.c_bgn   = bgn_reg;
    assign bus.cos_out = cos_reg;
    assign bus.neg     = neg_reg;
    assign bus.done    = done_reg;

endmodule

// File: tb/tb_cordic_range.sv
// Scoreboard bench for cordic_range: driver pushes model results, a core stub answers c_bgn,
// and a monitor checks theta/neg/latency at c_bgn and cos_out/timing at done.
module tb_cordic_range;

    localparam int PI_I      = 12868;
    localparam int TWO_PI_I  = 25736;
    localparam int HALF_PI_I = 6434;

    typedef struct {
        logic [15:0] angle;
        logic [15:0] theta;
        logic        neg;
        logic [15:0] cos;
        int          lat;
        int          start_cyc;
    } exp_t;

    typedef struct {
        logic [15:0] cos;
        int          delay;
        bit          early;
    } plan_t;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   fin_cyc = 0;
    int   bgn_cnt = 0;
    exp_t  exp_q[$];
    plan_t plan_q[$];

    cordic_range_if bus();

    cordic_range dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: reduce by whole turns, mirror about +/-pi/2, then sign-correct the core output.
    function automatic exp_t model(input logic [15:0] ang, input logic [15:0] cc);
        exp_t        e;
        int          a;
        int          f;
        int          v;
        logic [31:0] fb;
        logic [31:0] vb;
        logic [15:0] w;
        a = int'($signed(ang));
        e.lat = 3;
        while (a > PI_I) begin a -= TWO_PI_I; e.lat++; end
        while (a < -PI_I) begin a += TWO_PI_I; e.lat++; end
        if (a > HALF_PI_I) begin
            f = PI_I - a; e.neg = 1'b1;
        end else if (a < -HALF_PI_I) begin
            f = -PI_I - a; e.neg = 1'b1;
        end else begin
            f = a; e.neg = 1'b0;
        end
        fb = f;
        e.theta = {fb[13:0], 2'b00};
        v = e.neg ? -int'($signed(cc)) : int'($signed(cc));
        vb = v;
        w = vb[15:0];
`ifdef CORDIC_RANGE_SAT_EN
        if ($signed(w) > 16'sh4000) w = 16'h4000;
        else if ($signed(w) < 16'shC000) w = 16'hC000;
`endif
        e.cos = w;
        e.angle = ang;
        e.start_cyc = 0;
        return e;
    endfunction

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.c_bgn === 1'b1 && exp_q.size() > 0) begin
                bgn_cnt++;
                if (bgn_cnt == 1) begin
                    e = exp_q[0];
                    chk("theta", bus.theta, e.theta);
                    chk("neg", 16'(bus.neg), 16'(e.neg));
                    // edge at which the core samples c_bgn, counted from the start-sampling edge
                    chk("bgn_latency", 16'(cyc + 1 - e.start_cyc), 16'(e.lat));
                end
            end
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: got done=1 expected no operation pending");
                end else begin
                    e = exp_q.pop_front();
                    chk("cos_out", bus.cos_out, e.cos);
                    chk("theta_hold", bus.theta, e.theta);
                    chk("bgn_pulses", 16'(bgn_cnt), 16'd1);
                    chk("done_timing", 16'(cyc), 16'(fin_cyc));
                    bgn_cnt = 0;
                end
            end
        end
    end

    // Core stub
    initial begin
        plan_t p;
        bus.c_fin = 1'b0;
        bus.c_cos = 16'h0000;
        forever begin
            @(negedge clk);
            if (bus.c_bgn === 1'b1 && plan_q.size() > 0) begin
                p = plan_q.pop_front();
                if (p.early) begin
                    bus.c_fin = 1'b1;
                    bus.c_cos = 16'($urandom);
                end
                @(negedge clk);
                bus.c_fin = 1'b0;
                repeat (p.delay - 1) @(negedge clk);
                bus.c_fin = 1'b1;
                bus.c_cos = p.cos;
                fin_cyc = cyc + 1;
                @(negedge clk);
                bus.c_fin = 1'b0;
                bus.c_cos = 16'($urandom);
            end
        end
    end

    task automatic run_op(input logic [15:0] ang, input logic [15:0] cc, input int delay,
                          input bit early, input int hold, input bit start_in_done);
        exp_t  e;
        plan_t p;
        int    n;
        e = model(ang, cc);
        p.cos = cc;
        p.delay = delay;
        p.early = early;
        plan_q.push_back(p);
        e.start_cyc = cyc + 1;
        exp_q.push_back(e);
        bus.angle = ang;
        bus.start = 1'b1;
        @(negedge clk);
        repeat (hold) @(negedge clk);
        bus.start = 1'b0;
        bus.angle = 16'($urandom);
        n = 0;
        while (bus.done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done for angle %h", n, ang);
            exp_q.delete();
            plan_q.delete();
        end
        if (start_in_done) begin
            bus.angle = 16'($urandom);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        @(negedge clk);
    endtask

    logic [15:0] dir_ang [10] = '{16'h0000, 16'h3244, 16'h7FFF, 16'h0000, 16'hCDBC,
                                  16'h1922, 16'hE6DE, 16'h1923, 16'h8000, 16'h3244};
    logic [15:0] dir_cos [10] = '{16'h4000, 16'h4000, 16'h4000, 16'h4010, 16'h3000,
                                  16'h1234, 16'h1234, 16'h2000, 16'h8000, 16'h8000};

    initial begin
        int n;
        plan_t p;
        bus.start = 1'b0;
        bus.angle = 16'h0000;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_theta", bus.theta, 16'h0000);
        chk("rst_cos_out", bus.cos_out, 16'h0000);
        chk("rst_neg", 16'(bus.neg), 16'd0);
        chk("rst_c_bgn", 16'(bus.c_bgn), 16'd0);
        chk("rst_done", 16'(bus.done), 16'd0);
        rst_b = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(dir_ang[i], dir_cos[i], 1 + (i % 3), 1'b0, 0, 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ang;
            logic [15:0] cc;
            ang = 16'($urandom);
            cc = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(16'h3F00, 16'h4100));
            run_op(ang, cc, $urandom_range(1, 5), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Abort mid-WAIT: stray start is ignored, reset clears everything, late c_fin is ignored.
        p.cos = 16'h1234;
        p.delay = 20;
        p.early = 1'b0;
        plan_q.push_back(p);
        bus.angle = 16'h0100;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.c_bgn !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL abort_bgn_timeout: got no c_bgn expected c_bgn within 50 cycles");
        end
        repeat (2) @(negedge clk);
        bus.angle = 16'h2000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk("abort_busy", 16'(bus.busy), 16'd0);
        chk("abort_theta", bus.theta, 16'h0000);
        chk("abort_cos_out", bus.cos_out, 16'h0000);
        chk("abort_neg", 16'(bus.neg), 16'd0);
        chk("abort_c_bgn", 16'(bus.c_bgn), 16'd0);
        chk("abort_done", 16'(bus.done), 16'd0);
        repeat (30) @(negedge clk);
        chk("abort_late_busy", 16'(bus.busy), 16'd0);
        chk("abort_late_cos_out", bus.cos_out, 16'h0000);
        chk("abort_plan_used", 16'(plan_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_range.md
CORDIC_RANGE -- requirements
Module: cordic_range

Purpose: upstream angle-reduction and sequencing stage for the cordic cosine core; folds any Q3.12 angle into [-pi/2, pi/2], drives the core, and sign-corrects its result.

Interface
REQ-001 Parameter TWO_PI, default 16'h6488, 2*pi in Q3.12.
REQ-002 Parameter PI, default 16'h3244, pi in Q3.12.
REQ-003 Parameter HALF_PI, default 16'h1922, pi/2 in Q3.12.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_b  input  1  reset, synchronous and active-high, despite the _b suffix.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 angle  input  16  signed Q3.12 angle, captured with start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 theta  output  16  signed Q2.14 folded angle to the core; registered.
REQ-010 c_bgn  output  1  one-cycle start pulse to the core.
REQ-011 c_fin  input  1  core completion flag.
REQ-012 c_cos  input  16  signed Q2.14 core result, valid when c_fin=1.
REQ-013 cos_out  output  16  signed Q2.14 sign-corrected cosine; holds until the next capture.
REQ-014 neg  output  1  result-negation flag for the current operation.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 FSM states: IDLE, REDUCE, FOLD, ISSUE, WAIT, DONE.
REQ-017 IDLE: on start=1, register a<=angle and go to REDUCE; start in any other state is ignored.
REQ-018 REDUCE, one step per cycle, signed compares:
- a>PI: a<=a-TWO_PI, stay.
- a<-PI: a<=a+TWO_PI, stay.
- otherwise: go to FOLD.
REQ-019 FOLD:
- a>HALF_PI: f=PI-a, neg<=1.
- a<-HALF_PI: f=-PI-a, neg<=1.
- otherwise: f=a, neg<=0.
- In all cases theta<={f[13:0],2'b00} (Q3.12 to Q2.14), then go to ISSUE.
REQ-020 Boundaries: a==PI or a==-PI gives theta=0, neg=1; a==HALF_PI or a==-HALF_PI is not folded.
REQ-021 ISSUE: c_bgn=1 for exactly this cycle, then go to WAIT.
REQ-022 WAIT: hold theta stable; on c_fin=1, cos_out<=neg ? -c_cos : c_cos (16-bit two's complement, wraps), then go to DONE.
REQ-023 DONE: done=1 for this cycle, then go to IDLE; a start in this cycle is ignored.
REQ-024 Latency for an in-range angle: c_bgn is high 3 cycles after the start-sampling edge, plus 1 cycle per REDUCE step; the full Q3.12 input range needs at most 1 step.
REQ-025 done rises the cycle after c_fin is sampled; c_fin outside WAIT is ignored.

Reset
REQ-026 With rst_b=1 at a clock edge: state<=IDLE, a/theta/cos_out<=0, neg/c_bgn/done/busy<=0.
REQ-027 Reset mid-operation (any state) aborts with no done pulse, and any later c_fin is ignored.

Configuration
REQ-028 Macro CORDIC_RANGE_SAT_EN defined: the value captured into cos_out is clamped to [16'hC000, 16'h4000] (+/-1.0) after sign correction.
REQ-029 Macro CORDIC_RANGE_SAT_EN undefined: no clamping; the raw sign-corrected value is captured.

Verification
REQ-030 angle=0x0000, stub c_cos=0x4000 -> theta=0x0000, neg=0, c_bgn 3 cycles after start, cos_out=0x4000, done pulse.
REQ-031 angle=0x3244 (pi), stub c_cos=0x4000 -> theta=0x0000, neg=1, cos_out=0xC000.
REQ-032 angle=0x7FFF -> one REDUCE step (a=0x1B77), fold to theta=0x5B34, neg=1, c_bgn 4 cycles after start.
REQ-033 Stub c_cos=0x4010, neg=0 -> cos_out=0x4000 with CORDIC_RANGE_SAT_EN, 0x4010 without.
REQ-034 start pulsed while in WAIT, then rst_b asserted mid-WAIT -> no second capture, no done, all outputs zero, busy=0.
